md5_block_feeder: RTL and testbench
===================================

# md5_block_feeder

Front-end writer for the dual-lane `md5unit`. It accepts a word-aligned byte message on a valid/ready stream and applies MD5 padding plus the 64-bit bit-length. It writes the resulting 16-word block into a free lane over the `write`/`writeaddr`/`writedata` port and pulses that lane's `start`. It then returns completed digests in message order on a valid/ready output. Messages are single-block only (≤55 bytes); longer messages are discarded and flagged.

## Interface

Parameters:
- `MAX_MSG_BYTES`, 55: largest message that fits one block; longer messages are errors.
- `START_GUARD`, 2: cycles after a `start` pulse during which that lane's `done` is ignored.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: feeder accepts the word.
- `in_data` in 32: message bytes, little-endian; byte k is in bits [8k+7:8k].
- `in_last` in 1: final word of the message.
- `in_bytes` in 3: valid bytes in the last word, 0..4; ignored when `in_last`=0.
- `write` out 1: `md5unit` word write strobe.
- `writeaddr` out 5: bit 4 = lane, bits 3:0 = word index.
- `writedata` out 32: block word.
- `start` out 2: one-cycle start pulse per lane.
- `done` in 2: per-lane level done from `md5unit`.
- `digest0`, `digest1` in 128: lane digests.
- `out_valid` out 1: digest available.
- `out_ready` in 1: consumer accepts the digest.
- `out_digest` out 128: digest of the oldest outstanding message.
- `err` out 1: one-cycle pulse when an over-length message has been dropped.

## Operation

- Lanes are dispatched round-robin, starting at lane 0. Per-lane `busy` is set on `start` and cleared when that lane's digest is handed off.
- Load FSM states: IDLE, LOAD, PAD, LEN_LO, LEN_HI, START, DRAIN.
  - IDLE→LOAD when `busy[wr_lane]`=0.
  - LOAD: `in_ready`=1. Each accepted word is written at address `{wr_lane, idx}`, then `idx` increments. The byte counter adds 4, or `in_bytes` on the last word.
  - On the last word with `in_bytes`<4: the written word keeps bytes below `in_bytes`, puts 8'h80 at byte `in_bytes`, and zeroes the bytes above. Go to PAD.
  - On the last word with `in_bytes`=4: the word is written unchanged, and PAD writes 32'h00000080 first.
  - PAD: writes zero words until `idx`=14, then LEN_LO.
  - LEN_LO writes word 14 = `bytes*8`. LEN_HI writes word 15 = 0.
  - START: pulses `start[wr_lane]`, sets `busy`, toggles `wr_lane`, returns to IDLE.
- Overflow conditions:
  - a word is accepted when `idx`=14;
  - the byte count exceeds `MAX_MSG_BYTES` on the last word.
  - On overflow: go to DRAIN, accept and discard words through `in_last`, pulse `err` on the cycle after `in_last` is accepted, and return to IDLE. No start is issued and `wr_lane` is unchanged.
- Collect side:
  - `out_valid` = `busy[rd_lane]` & `done[rd_lane]` & guard expired.
  - `out_digest` = `digest0` or `digest1` selected by `rd_lane` (combinational).
  - On `out_valid`&`out_ready`: clear `busy[rd_lane]` and toggle `rd_lane`.
- Load and collect run concurrently. Handing off one lane's digest and starting a new block on the other lane in the same cycle is legal.

## Timing

- Reset values: `in_ready`, `write`, `writeaddr`, `writedata`, `start`, `out_valid`, `err` = 0; `busy`=0; `wr_lane`=`rd_lane`=0; FSM in IDLE.
- `write`/`writeaddr`/`writedata` are registered. A word appears one cycle after it is accepted. Padding and length words follow at one word per cycle with no gaps.
- `start` is asserted the cycle after the word-15 write. Minimum block cost is 16 writes + 1 start cycle. With an unstalled input, the next message can be accepted one cycle after `start`.
- Guard: `done[u]` is ignored in the `start` cycle and the `START_GUARD-1` cycles after it, so a stale high `done` is never taken as completion.
- `out_valid`, once high, stays high with `out_digest` stable until `out_ready`.
- Input stalls (`in_valid`=0) during LOAD simply pause the FSM; no write is issued.
- A reset mid-operation abandons all in-flight blocks and busy state. The next message goes to lane 0.

## Structure

- Package `md5_feed_pkg`:
  - load state enum;
  - `PAD_BYTE`=8'h80, `LEN_LO_IDX`=14, `LEN_HI_IDX`=15;
  - lane index type.
- Sub-module `md5_pad_word`: combinational; takes (`in_data`, `in_bytes`) and returns the masked word with 8'h80 inserted.

## Test plan

- **42-byte message.** Words 0x01680208, 0x13ab80bb, … 0x eff0be7c, then 0x????8533 with `in_bytes`=2 → writes 0..15 are:
  - word 10 = 0x00808533;
  - words 11–13 = 0;
  - word 14 = 0x00000150;
  - word 15 = 0.
  - Then `start`=2'b01, and `out_digest` = 128'hbaebddf861d3eb2714ba892c2ad26682.
- **Empty message.** One word, `in_last`=1, `in_bytes`=0 → word 0 = 0x00000080, words 1–15 = 0, `start[0]` pulses.
- **52-byte message.** 13 full words → word 13 = 0x00000080, word 14 = 0x000001A0.
- **56-byte message.** → `err` pulses once after `in_last`, no `start`, and the next 1-byte message is dispatched to lane 0.
- **Three messages back-to-back, `out_ready`=0.**
  - Messages go to lane 0 and lane 1 (`writeaddr[4]` toggles).
  - The third stalls with `in_ready`=0.
  - `out_valid` holds lane 0's digest stable.
  - Raising `out_ready` releases the digests in order, and the third message then loads into lane 0.
- **Reset asserted mid-LOAD (word 5).** → all outputs are 0 asynchronously; after release, a fresh 42-byte message produces the full sequence on lane 0.

Source files
------------

// File: rtl/md5_feed_pkg.sv
// Shared types and constants for the MD5 single-block feeder.
package md5_feed_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_LEN_LO,
    S_LEN_HI,
    S_START,
    S_DRAIN
  } load_state_e;

  localparam logic [7:0] PAD_BYTE   = 8'h80;
  localparam logic [3:0] LEN_LO_IDX = 4'd14;
  localparam logic [3:0] LEN_HI_IDX = 4'd15;

  typedef logic lane_t;

endpackage

// File: rtl/md5_pad_word.sv
// Final-word shaping: keep bytes below nbytes_i, drop the 0x80 marker at
// byte nbytes_i, zero everything above.
module md5_pad_word
  import md5_feed_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
  output logic [31:0] word_o
);

  for (genvar k = 0; k < 4; k++) begin : g_byte
    localparam logic [2:0] K = 3'(k);
    assign word_o[8*k +: 8] = (K < nbytes_i)  ? data_i[8*k +: 8] :
                              (K == nbytes_i) ? PAD_BYTE : 8'h00;
  end

endmodule

// File: rtl/md5_block_feeder.sv
// Loads padded single-block messages into a dual-lane md5unit round-robin
// and returns the digests in message order.
module md5_block_feeder
  import md5_feed_pkg::*;
#(
  parameter int MAX_MSG_BYTES = 55,
  parameter int START_GUARD   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         write,
  output logic [4:0]   writeaddr,
  output logic [31:0]  writedata,
  output logic [1:0]   start,
  input  logic [1:0]   done,
  input  logic [127:0] digest0,
  input  logic [127:0] digest1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_digest,
  output logic         err
);

  localparam logic [6:0] MAX_B = 7'(MAX_MSG_BYTES);

  load_state_e state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [6:0]  bytes_q, bytes_d;
  logic        need80_q, need80_d;
  lane_t       wr_lane_q, wr_lane_d, rd_lane_q, rd_lane_d;
  logic [1:0]  busy_q, busy_d;
  logic [1:0][START_GUARD-1:0] guard_q, guard_d;
  logic        write_q, write_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  start_q, start_d;
  logic        err_q, err_d;

  logic [31:0] pad_word;
  logic [6:0]  new_bytes;
  logic        handoff;

  md5_pad_word u_pad (
    .data_i   (in_data),
    .nbytes_i (in_bytes),
    .word_o   (pad_word)
  );

  assign in_ready  = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign new_bytes = bytes_q + (in_last ? {4'd0, in_bytes} : 7'd4);

  // A lane's done only counts once its post-start guard window has drained.
  assign out_valid  = busy_q[rd_lane_q] & done[rd_lane_q] & ~|guard_q[rd_lane_q];
  assign out_digest = rd_lane_q ? digest1 : digest0;
  assign handoff    = out_valid & out_ready;

  assign write     = write_q;
  assign writeaddr = waddr_q;
  assign writedata = wdata_q;
  assign start     = start_q;
  assign err       = err_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bytes_d   = bytes_q;
    need80_d  = need80_q;
    wr_lane_d = wr_lane_q;
    write_d   = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    start_d   = '0;
    err_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        idx_d    = '0;
        bytes_d  = '0;
        need80_d = 1'b0;
        if (!busy_q[wr_lane_q]) state_d = S_LOAD;
      end
      S_LOAD: if (in_valid) begin
        if (idx_q == LEN_LO_IDX) begin
          if (in_last) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (in_last && (new_bytes > MAX_B)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          write_d = 1'b1;
          waddr_d = {wr_lane_q, idx_q};
          wdata_d = (in_last && in_bytes != 3'd4) ? pad_word : in_data;
          idx_d   = idx_q + 4'd1;
          bytes_d = new_bytes;
          if (in_last) begin
            need80_d = (in_bytes == 3'd4);
            // A 55-byte tail lands on word 13, so the length words follow directly.
            state_d  = (in_bytes == 3'd4 || idx_q != LEN_LO_IDX - 4'd1) ? S_PAD : S_LEN_LO;
          end
        end
      end
      S_PAD: begin
        write_d  = 1'b1;
        waddr_d  = {wr_lane_q, idx_q};
        wdata_d  = need80_q ? {24'd0, PAD_BYTE} : 32'd0;
        need80_d = 1'b0;
        idx_d    = idx_q + 4'd1;
        if (idx_q == LEN_LO_IDX - 4'd1) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        write_d = 1'b1;
        waddr_d = {wr_lane_q, LEN_LO_IDX};
        wdata_d = {22'd0, bytes_q, 3'd0};
        state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        write_d = 1'b1;
        waddr_d = {wr_lane_q, LEN_HI_IDX};
        wdata_d = 32'd0;
        state_d = S_START;
      end
      S_START: begin
        start_d[wr_lane_q] = 1'b1;
        wr_lane_d          = ~wr_lane_q;
        state_d            = S_IDLE;
      end
      S_DRAIN: if (in_valid && in_last) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d    = busy_q;
    rd_lane_d = rd_lane_q;
    for (int u = 0; u < 2; u++) guard_d[u] = guard_q[u] >> 1;
    if (handoff) begin
      busy_d[rd_lane_q] = 1'b0;
      rd_lane_d         = ~rd_lane_q;
    end
    if (state_q == S_START) begin
      busy_d[wr_lane_q]  = 1'b1;
      guard_d[wr_lane_q] = '1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      bytes_q   <= '0;
      need80_q  <= 1'b0;
      wr_lane_q <= 1'b0;
      rd_lane_q <= 1'b0;
      busy_q    <= '0;
      guard_q   <= '0;
      write_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      start_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bytes_q   <= bytes_d;
      need80_q  <= need80_d;
      wr_lane_q <= wr_lane_d;
      rd_lane_q <= rd_lane_d;
      busy_q    <= busy_d;
      guard_q   <= guard_d;
      write_q   <= write_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      start_q   <= start_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_md5_block_feeder.sv
// Directed bench for md5_block_feeder: block contents, lane order, guard,
// overflow handling and reset recovery.
module tb_md5_block_feeder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_last;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         write;
  logic [4:0]   writeaddr;
  logic [31:0]  writedata;
  logic [1:0]   start, done;
  logic [127:0] digest0, digest1, out_digest;
  logic         out_valid, out_ready, err;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] DIG42 = 128'hbaebddf861d3eb2714ba892c2ad26682;
  localparam logic [127:0] DA    = 128'h0123456789abcdef0011223344556677;
  localparam logic [127:0] DB    = 128'hfedcba9876543210ffeeddccbbaa9988;

  logic [31:0] m42 [11] = '{32'h01680208, 32'h13ab80bb, 32'h2c4f9e01, 32'h7d35a6c2,
                            32'h90e1f344, 32'h5b7c2d18, 32'hc3a94e67, 32'h0f8b17d5,
                            32'h66e2b0a9, 32'heff0be7c, 32'hdead8533};

  md5_block_feeder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .write(write), .writeaddr(writeaddr), .writedata(writedata),
    .start(start), .done(done), .digest0(digest0), .digest1(digest1),
    .out_valid(out_valid), .out_ready(out_ready), .out_digest(out_digest),
    .err(err)
  );

  always #5 clk = ~clk;

  // Write/start/err monitor; the only process that touches these.
  logic [31:0] wmem [32];
  int   cyc = 0, wcnt = 0, start_cnt = 0, err_cnt = 0;
  int   w15_cyc = 0, w0_cyc = 0, start_cyc = 0;
  logic [1:0] start_val = 2'b00;
  logic       w15_lane = 1'b0;
  logic [2:0] ov_hist = 3'b000;

  always @(negedge clk) begin
    cyc++;
    if (write) begin
      wmem[writeaddr] = writedata;
      wcnt++;
      if (writeaddr[3:0] == 4'd15) begin w15_cyc = cyc; w15_lane = writeaddr[4]; end
      if (writeaddr[3:0] == 4'd0) w0_cyc = cyc;
    end
    if (start != 2'b00) begin start_cnt++; start_val = start; start_cyc = cyc; end
    if (err) err_cnt++;
    ov_hist = {ov_hist[1:0], out_valid};
  end

  task automatic do_reset();
    in_valid = 0; in_data = 0; in_last = 0; in_bytes = 0;
    out_ready = 0; done = 0; digest0 = 0; digest1 = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b);
    int n;
    in_valid = 1; in_data = d; in_last = l; in_bytes = b; n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_word_timeout: in_ready=%b required 1 for word %h", in_ready, d);
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0; in_bytes = 0;
  endtask

  task automatic wait_start(input int base);
    int n;
    n = 0;
    while (start_cnt == base && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (start_cnt == base) begin
      errors++;
      $display("FAIL start_seen: no start pulse after %0d cycles, required one", n);
    end
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; in_data = 0; in_last = 0; in_bytes = 0;
    out_ready = 0; done = 2'b11; digest0 = 0; digest1 = 0;
    repeat (3) @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (write !== 1'b0)      begin errors++; $display("FAIL rst_write: got %b want 0", write); end
    checks++; if (writeaddr !== 5'd0)  begin errors++; $display("FAIL rst_writeaddr: got %h want 0", writeaddr); end
    checks++; if (writedata !== 32'd0) begin errors++; $display("FAIL rst_writedata: got %h want 0", writedata); end
    checks++; if (start !== 2'b00)     begin errors++; $display("FAIL rst_start: got %b want 00", start); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    reset = 0; done = 0;
    repeat (2) @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_msg42();
    int bw, bs, n;
    logic [31:0] e;
    bw = wcnt; bs = start_cnt;
    for (int i = 0; i < 10; i++) send_word(m42[i], 1'b0, 3'd0);
    send_word(m42[10], 1'b1, 3'd2);
    wait_start(bs);
    @(posedge clk); #1;
    checks++; if (wcnt - bw !== 16) begin errors++; $display("FAIL m42_wcount: got %0d want 16", wcnt - bw); end
    for (int i = 0; i < 16; i++) begin
      e = (i < 10) ? m42[i] : (i == 10) ? 32'h00808533 : (i == 14) ? 32'h00000150 : 32'h0;
      checks++;
      if (wmem[i] !== e) begin errors++; $display("FAIL m42_word%0d: got %h want %h", i, wmem[i], e); end
    end
    checks++; if (start_val !== 2'b01) begin errors++; $display("FAIL m42_start: got %b want 01", start_val); end
    checks++; if (start_cyc !== w15_cyc + 1) begin errors++; $display("FAIL m42_start_cycle: got %0d want %0d", start_cyc, w15_cyc + 1); end
    digest0 = DIG42; digest1 = ~DIG42; done = 2'b01;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL m42_out_valid: got %b want 1", out_valid); end
    checks++; if (out_digest !== DIG42) begin errors++; $display("FAIL m42_digest: got %h want %h", out_digest, DIG42); end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m42_handoff: out_valid=%b want 0", out_valid); end
    done = 0;
  endtask

  task automatic test_empty();
    int bw, bs;
    do_reset();
    done = 2'b01;  // stale done must not be mistaken for completion
    bw = wcnt; bs = start_cnt;
    send_word(32'hffffffff, 1'b1, 3'd0);
    wait_start(bs);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (ov_hist !== 3'b001) begin errors++; $display("FAIL empty_guard: out_valid history %b want 001", ov_hist); end
    checks++; if (start_val !== 2'b01) begin errors++; $display("FAIL empty_start: got %b want 01", start_val); end
    checks++; if (wcnt - bw !== 16) begin errors++; $display("FAIL empty_wcount: got %0d want 16", wcnt - bw); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (wmem[i] !== ((i == 0) ? 32'h00000080 : 32'h0))
        begin errors++; $display("FAIL empty_word%0d: got %h", i, wmem[i]); end
    end
    done = 0;
  endtask

  task automatic test_msg52();
    int bw, bs;
    logic [31:0] e;
    do_reset();
    bw = wcnt; bs = start_cnt;
    for (int i = 0; i < 12; i++) send_word(32'h0a0b0c00 + i, 1'b0, 3'd1);
    send_word(32'h0a0b0c0c, 1'b1, 3'd4);
    wait_start(bs);
    @(posedge clk); #1;
    checks++; if (wcnt - bw !== 16) begin errors++; $display("FAIL m52_wcount: got %0d want 16", wcnt - bw); end
    for (int i = 0; i < 16; i++) begin
      e = (i < 13) ? 32'h0a0b0c00 + i : (i == 13) ? 32'h00000080 : (i == 14) ? 32'h000001a0 : 32'h0;
      checks++;
      if (wmem[i] !== e) begin errors++; $display("FAIL m52_word%0d: got %h want %h", i, wmem[i], e); end
    end
  endtask

  task automatic test_overflow();
    int be, bs, bw;
    do_reset();
    be = err_cnt; bs = start_cnt;
    for (int i = 0; i < 13; i++) send_word(32'h5a5a0000 + i, 1'b0, 3'd0);
    send_word(32'h5a5a000d, 1'b1, 3'd4);  // 56 bytes
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf56_err_pulse: got %b want 1", err); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf56_err_width: got %b want 0", err); end
    for (int i = 0; i < 15; i++) send_word(32'h77770000 + i, 1'b0, 3'd0);
    send_word(32'h7777000f, 1'b1, 3'd4);  // 64 bytes, overflows at word 14
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf64_err_pulse: got %b want 1", err); end
    repeat (4) @(negedge clk);
    checks++; if (err_cnt - be !== 2) begin errors++; $display("FAIL ovf_err_count: got %0d want 2", err_cnt - be); end
    checks++; if (start_cnt !== bs) begin errors++; $display("FAIL ovf_no_start: got %0d starts want 0", start_cnt - bs); end
    bw = wcnt;
    @(posedge clk); #1;
    send_word(32'h123456ab, 1'b1, 3'd1);
    wait_start(bs);
    @(posedge clk); #1;
    checks++; if (start_val !== 2'b01) begin errors++; $display("FAIL ovf_next_start: got %b want 01", start_val); end
    checks++; if (w15_lane !== 1'b0) begin errors++; $display("FAIL ovf_next_lane: got %b want 0", w15_lane); end
    checks++; if (wcnt - bw !== 16) begin errors++; $display("FAIL ovf_next_wcount: got %0d want 16", wcnt - bw); end
    checks++; if (wmem[0] !== 32'h000080ab) begin errors++; $display("FAIL ovf_next_word0: got %h want 000080ab", wmem[0]); end
    checks++; if (wmem[14] !== 32'h00000008) begin errors++; $display("FAIL ovf_next_len: got %h want 00000008", wmem[14]); end
    checks++; if (wmem[13] !== 32'h0) begin errors++; $display("FAIL ovf_next_word13: got %h want 0", wmem[13]); end
  endtask

  task automatic test_back_to_back();
    int bs, a_start;
    do_reset();
    bs = start_cnt;
    send_word(32'h11111111, 1'b1, 3'd4);
    send_word(32'h22222222, 1'b1, 3'd4);
    a_start = start_cyc;
    checks++; if (start_cnt - bs !== 1) begin errors++; $display("FAIL b2b_a_started: got %0d starts want 1", start_cnt - bs); end
    checks++; if (start_val !== 2'b01) begin errors++; $display("FAIL b2b_a_start: got %b want 01", start_val); end
    checks++; if (w15_lane !== 1'b0) begin errors++; $display("FAIL b2b_a_lane: got %b want 0", w15_lane); end
    checks++; if (wmem[0] !== 32'h11111111 || wmem[1] !== 32'h80)
      begin errors++; $display("FAIL b2b_a_words: got %h %h want 11111111 00000080", wmem[0], wmem[1]); end
    wait_start(bs + 1);
    @(posedge clk); #1;
    checks++; if (start_val !== 2'b10) begin errors++; $display("FAIL b2b_b_start: got %b want 10", start_val); end
    checks++; if (w15_lane !== 1'b1) begin errors++; $display("FAIL b2b_b_lane: got %b want 1", w15_lane); end
    checks++; if (wmem[16] !== 32'h22222222 || wmem[17] !== 32'h80 || wmem[30] !== 32'h20)
      begin errors++; $display("FAIL b2b_b_words: got %h %h %h", wmem[16], wmem[17], wmem[30]); end
    checks++; if (w0_cyc - a_start !== 2) begin errors++; $display("FAIL b2b_turnaround: got %0d cycles want 2", w0_cyc - a_start); end
    digest0 = DA; digest1 = DB; done = 2'b11;
    in_valid = 1; in_data = 32'h33333333; in_last = 1; in_bytes = 3'd4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall%0d: in_ready=%b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_digest !== DA)
        begin errors++; $display("FAIL b2b_hold%0d: valid=%b digest=%h want 1 %h", i, out_valid, out_digest, DA); end
    end
    @(posedge clk); #1 out_ready = 1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_digest !== DA) begin errors++; $display("FAIL b2b_first: valid=%b digest=%h", out_valid, out_digest); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_digest !== DB) begin errors++; $display("FAIL b2b_second: valid=%b digest=%h", out_valid, out_digest); end
    @(posedge clk); #1 out_ready = 0; done = 2'b00;
    send_word(32'h33333333, 1'b1, 3'd4);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: out_valid=%b want 0", out_valid); end
    wait_start(bs + 2);
    @(posedge clk); #1;
    checks++; if (start_val !== 2'b01 || w15_lane !== 1'b0) begin errors++; $display("FAIL b2b_c_lane: start=%b lane=%b want 01 0", start_val, w15_lane); end
    checks++; if (wmem[0] !== 32'h33333333) begin errors++; $display("FAIL b2b_c_word0: got %h want 33333333", wmem[0]); end
  endtask

  task automatic test_reset_mid();
    int bs;
    do_reset();
    bs = start_cnt;
    send_word(32'h0, 1'b1, 3'd0);  // occupy lane 0
    wait_start(bs);
    for (int i = 0; i < 5; i++) send_word(m42[i], 1'b0, 3'd0);
    checks++; if (write !== 1'b1 || writeaddr !== 5'h14)
      begin errors++; $display("FAIL mid_pre: write=%b addr=%h want 1 14", write, writeaddr); end
    in_valid = 1; in_data = m42[5];
    #1 reset = 1;
    #1;
    checks++; if (write !== 1'b0 || writeaddr !== 5'd0 || writedata !== 32'd0)
      begin errors++; $display("FAIL mid_rst_write: %b %h %h want 0 0 0", write, writeaddr, writedata); end
    checks++; if (in_ready !== 1'b0 || start !== 2'b00 || out_valid !== 1'b0 || err !== 1'b0)
      begin errors++; $display("FAIL mid_rst_ctrl: rdy=%b start=%b ov=%b err=%b want 0", in_ready, start, out_valid, err); end
    in_valid = 0;
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1;
    test_msg42();
  endtask

  initial begin
    reset = 1;
    test_reset();
    test_msg42();
    test_empty();
    test_msg52();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
